// File: rtl/xdisp_mux.sv
// Multiplexed seven-segment display controller on the picoVersat bus.
// Scans N_DIGITS with a one-cycle dead slot between digits.
module xdisp_mux #(
  parameter int N_DIGITS    = 4,
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 32,
  parameter int DIV_W       = 16,
  parameter int DIV_RST     = 50000,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit SEL_ACT_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   data_in,
  output logic [DATA_W-1:0]   data_out,
  output logic [7:0]          Disp,
  output logic [N_DIGITS-1:0] Disp_sel
);

  localparam int IW = $clog2(N_DIGITS);
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(N_DIGITS);
  localparam logic [ADDR_W-1:0] A_DIV  = ADDR_W'(N_DIGITS + 1);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(N_DIGITS + 2);
  localparam logic [7:0] SEG_OFF = {8{SEG_ACT_LOW}};
  localparam logic [N_DIGITS-1:0] SEL_OFF = {N_DIGITS{SEL_ACT_LOW}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } state_t;

  state_t                r_state;
  logic [7:0]            r_digit [N_DIGITS];
  logic                  r_en;
  logic                  r_raw;
  logic [N_DIGITS-1:0]   r_blank;
  logic [DIV_W-1:0]      r_div;
  logic [DIV_W-1:0]      r_pre;
  logic [IW-1:0]         r_idx;

  logic                  w_wr;
  logic                  w_rd;
  logic                  w_div_wr;
  logic                  w_is_dig;
  logic                  w_show;
  logic [7:0]            w_src;
  logic [6:0]            w_hex;
  logic [7:0]            w_seg;
  logic [N_DIGITS-1:0]   w_onehot;
  logic [DATA_W-1:0]     w_rdata;
  logic                  w_unused;

  assign w_wr     = sel & we;
  assign w_rd     = sel & ~we;
  assign w_div_wr = w_wr && (addr == A_DIV);
  assign w_is_dig = addr < A_CTRL;
  assign w_unused = ^data_in;

  assign w_src    = r_digit[r_idx];
  assign w_seg    = r_raw ? w_src : {w_src[7], w_hex};
  assign w_show   = r_en && (r_state == S_SHOW);
  assign w_onehot = N_DIGITS'(1) << r_idx;

  always_comb begin
    w_hex = 7'h00;
    unique case (w_src[3:0])
      4'h0: w_hex = 7'h3F;
      4'h1: w_hex = 7'h06;
      4'h2: w_hex = 7'h5B;
      4'h3: w_hex = 7'h4F;
      4'h4: w_hex = 7'h66;
      4'h5: w_hex = 7'h6D;
      4'h6: w_hex = 7'h7D;
      4'h7: w_hex = 7'h07;
      4'h8: w_hex = 7'h7F;
      4'h9: w_hex = 7'h6F;
      4'hA: w_hex = 7'h77;
      4'hB: w_hex = 7'h7C;
      4'hC: w_hex = 7'h39;
      4'hD: w_hex = 7'h5E;
      4'hE: w_hex = 7'h79;
      4'hF: w_hex = 7'h71;
    endcase
  end

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_is_dig: w_rdata[7:0] = r_digit[addr[IW-1:0]];
      (addr == A_CTRL): begin
        w_rdata[0] = r_en;
        w_rdata[1] = r_raw;
        w_rdata[8 +: N_DIGITS] = r_blank;
      end
      (addr == A_DIV): w_rdata[DIV_W-1:0] = r_div;
      (addr == A_STAT): begin
        w_rdata[IW-1:0] = r_idx;
        w_rdata[8] = (r_state == S_SHOW);
      end
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_DIGITS; i++) r_digit[i] <= '0;
      r_en     <= 1'b1;
      r_raw    <= 1'b0;
      r_blank  <= '0;
      r_div    <= DIV_W'(DIV_RST);
      data_out <= '0;
    end else begin
      for (int i = 0; i < N_DIGITS; i++)
        if (w_wr && addr == ADDR_W'(i)) r_digit[i] <= data_in[7:0];
      if (w_wr && addr == A_CTRL) begin
        r_en    <= data_in[0];
        r_raw   <= data_in[1];
        r_blank <= data_in[8 +: N_DIGITS];
      end
      if (w_div_wr) r_div <= data_in[DIV_W-1:0];
      if (w_rd) data_out <= w_rdata;
    end
  end

  // A DIV write restarts the current digit's dwell instead of ending it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_BLANK;
      r_idx    <= '0;
      r_pre    <= '0;
      Disp     <= SEG_OFF;
      Disp_sel <= SEL_OFF;
    end else begin
      Disp     <= w_show ? (w_seg ^ SEG_OFF) : SEG_OFF;
      Disp_sel <= (w_show && !r_blank[r_idx]) ? (w_onehot ^ SEL_OFF)
                                              : SEL_OFF;
      if (!r_en) begin
        r_state <= S_IDLE;
        r_idx   <= '0;
        r_pre   <= '0;
      end else begin
        unique case (r_state)
          S_IDLE:  r_state <= S_BLANK;
          S_BLANK: r_state <= S_SHOW;
          S_SHOW: begin
            if (w_div_wr) begin
              r_pre <= '0;
            end else if (r_pre == r_div) begin
              r_pre   <= '0;
              r_state <= S_BLANK;
              r_idx   <= (r_idx == IW'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end else begin
              r_pre <= r_pre + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
